// File: rtl/mbssoc_uart_tx_pkg.sv
// Shared constants and types for the UART transmit responder.
//   UART_DATA_ADDR        : CPU store address decoded by the bus controller
//   UART_CLK_DIV_DEFAULT  : clk cycles per bit (50 MHz / 115200)
//   UART_FIFO_AW_DEFAULT  : transmit FIFO address width (depth 16)
package mbssoc_uart_tx_pkg;

  localparam logic [31:0] UART_DATA_ADDR       = 32'h1000_0000;
  localparam int unsigned UART_CLK_DIV_DEFAULT = 434;
  localparam int unsigned UART_FIFO_AW_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_tx_state_e;

endpackage

// File: rtl/mbssoc_uart_tx_if.sv
// Bus-controller side of the UART transmitter.
//   uart_we    : write strobe, one cycle per store
//   data_in    : store data, bits [7:0] carry the character
//   fifo_full  : FIFO holds 2**FIFO_AW bytes
//   fifo_count : bytes queued, excluding the one being shifted
//   tx_busy    : a frame is in progress
//   wr_drop    : one-cycle pulse, a strobe was discarded because the FIFO was full
// master = bus controller, slave = transmitter.
interface mbssoc_uart_tx_if
  import mbssoc_uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_AW    = UART_FIFO_AW_DEFAULT
);
  logic                  uart_we;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  fifo_full;
  logic [FIFO_AW:0]      fifo_count;
  logic                  tx_busy;
  logic                  wr_drop;

  modport master (
    output uart_we, data_in,
    input  fifo_full, fifo_count, tx_busy, wr_drop
  );

  modport slave (
    input  uart_we, data_in,
    output fifo_full, fifo_count, tx_busy, wr_drop
  );
endinterface

// File: rtl/mbssoc_sync_fifo.sv
// Parameterised synchronous FIFO, first-word fall-through read.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write wdata when not full (full as registered)
//   pop      : advance the read pointer when not empty
//   rdata    : head entry
//   full     : count == 2**AW
//   empty    : count == 0
//   count    : entries held (AW+1 bits so full is representable)
module mbssoc_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  localparam int unsigned DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push while full is refused even if a pop happens on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  // count never exceeds DEPTH, so its MSB alone marks full.
  assign full  = count[AW];
  assign empty = (count == '0);
endmodule

// File: rtl/mbssoc_uart_tx.sv
// Write-only UART transmitter: queues the low byte of each strobed store and
// sends it as an 8N1 frame, LSB first, idle-high line.
//   clk, rst : clock, asynchronous active-high reset (tx goes high at once)
//   bus      : strobe/data in, full/count/busy/drop status out
//   tx       : registered serial output
module mbssoc_uart_tx
  import mbssoc_uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CLK_DIV    = UART_CLK_DIV_DEFAULT,
  parameter int unsigned FIFO_AW    = UART_FIFO_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  mbssoc_uart_tx_if.slave   bus,
  output logic              tx
);
  localparam int unsigned       CNT_W   = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLK_DIV - 1);

  uart_tx_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             wr_drop_q;
  logic             bit_tick;
  logic             pop;
  logic [7:0]       fifo_rdata;
  logic             fifo_empty;
  logic             fifo_full;
  logic [FIFO_AW:0] fifo_count;
  logic             unused_data_hi;

  assign unused_data_hi = ^bus.data_in[DATA_WIDTH-1:8];

  mbssoc_sync_fifo #(
    .WIDTH (8),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.uart_we),
    .pop   (pop),
    .wdata (bus.data_in[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bit_tick = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          idx_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            idx_d   = '0;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Baud counter restarts on every state entry and at each bit boundary.
    cnt_d = (bit_tick || (state_d != state_q) || (state_q == ST_IDLE)) ? '0 : cnt_q + 1'b1;

    // tx is computed from the next state so the register leads the frame by no cycle.
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      wr_drop_q <= bus.uart_we && fifo_full;
    end
  end

  assign tx             = tx_q;
  assign bus.fifo_full  = fifo_full;
  assign bus.fifo_count = fifo_count;
  assign bus.tx_busy    = (state_q != ST_IDLE);
  assign bus.wr_drop    = wr_drop_q;
endmodule

// File: tb/tb_mbssoc_uart_tx.sv
// Bench for mbssoc_uart_tx at CLK_DIV=4: single-frame vector table, back-to-back
// frames, overflow/drop and asynchronous reset mid-frame. A line monitor decodes
// frames and checks them against a queue of expected bytes.
module tb_mbssoc_uart_tx;
  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned DW      = 32;
  localparam int unsigned AW      = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;

  always #5 clk = ~clk;

  mbssoc_uart_tx_if #(.DATA_WIDTH(DW), .FIFO_AW(AW)) bus_if ();

  mbssoc_uart_tx #(
    .DATA_WIDTH (DW),
    .CLK_DIV    (CLK_DIV),
    .FIFO_AW    (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if),
    .tx  (tx)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [7:0]  sb[$];

  typedef struct {
    logic [31:0] din;
    logic [7:0]  byte_exp;
    int unsigned busy_exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line monitor: samples each bit 1.5 cycles after its start; a reset during
  // the frame discards it.
  initial begin : monitor
    logic [9:0] bits;
    logic [7:0] exp_b;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        aborted = 1'b0;
        for (int b = 0; b < 10; b++) begin
          for (int k = 0; k < ((b == 0) ? 1 : int'(CLK_DIV)); k++) begin
            @(negedge clk);
            if (rst) aborted = 1'b1;
          end
          bits[b] = tx;
        end
        if (!aborted) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL frame: unexpected frame %03h, no byte expected", bits);
          end else begin
            exp_b = sb.pop_front();
            check("frame", {22'b0, bits}, {22'b0, 1'b1, exp_b, 1'b0});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    n_vec++;
    n_bad++;
    $display("FAIL timeout: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin : main
    vec_t        tbl[4];
    logic [4:0]  cnt3[3];
    int unsigned busy_cycles;
    int unsigned guard;
    int unsigned exp_cnt;
    bit          ok;

    tbl[0] = '{32'h0000_00A5, 8'hA5, 40};
    tbl[1] = '{32'hDEAD_BE3C, 8'h3C, 40};
    tbl[2] = '{32'h0000_0000, 8'h00, 40};
    tbl[3] = '{32'hFFFF_FF81, 8'h81, 40};
    cnt3[0] = 5'd1;
    cnt3[1] = 5'd1;
    cnt3[2] = 5'd2;

    bus_if.uart_we = 1'b0;
    bus_if.data_in = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx",      tx, 1);
    check("rst_full",    bus_if.fifo_full, 0);
    check("rst_count",   bus_if.fifo_count, 0);
    check("rst_busy",    bus_if.tx_busy, 0);
    check("rst_wr_drop", bus_if.wr_drop, 0);
    rst = 1'b0;

    ok = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || bus_if.tx_busy !== 1'b0 || bus_if.fifo_count !== '0) ok = 1'b0;
    end
    check("idle_100", ok, 1);

    // Single-frame table
    for (int i = 0; i < 4; i++) begin
      sb.push_back(tbl[i].byte_exp);
      bus_if.uart_we = 1'b1;
      bus_if.data_in = tbl[i].din;
      @(negedge clk);
      bus_if.uart_we = 1'b0;
      check("lat_e0_tx",    tx, 1);
      check("lat_e0_count", bus_if.fifo_count, 1);
      @(negedge clk);
      check("start_tx",    tx, 0);
      check("start_busy",  bus_if.tx_busy, 1);
      check("start_count", bus_if.fifo_count, 0);
      busy_cycles = 1;
      guard = 0;
      while (bus_if.tx_busy && guard < 200) begin
        @(negedge clk);
        guard++;
        if (bus_if.tx_busy) busy_cycles++;
      end
      check("busy_cycles", busy_cycles, tbl[i].busy_exp);
      repeat (3) @(negedge clk);
      check("sb_empty", sb.size(), 0);
    end

    // Three back-to-back strobes
    busy_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(8'(8'h11 * (i + 1)));
      bus_if.uart_we = 1'b1;
      bus_if.data_in = 32'(8'h11 * (i + 1));
      @(negedge clk);
      check("b2b_count", bus_if.fifo_count, cnt3[i]);
      if (bus_if.tx_busy) busy_cycles++;
    end
    bus_if.uart_we = 1'b0;
    guard = 0;
    while (bus_if.tx_busy && guard < 500) begin
      @(negedge clk);
      guard++;
      if (bus_if.tx_busy) busy_cycles++;
    end
    check("b2b_busy_total", busy_cycles, 120);
    check("b2b_drained",    bus_if.fifo_count, 0);
    repeat (3) @(negedge clk);
    check("b2b_sb_empty", sb.size(), 0);

    // Overflow: 18 strobes, the last one is dropped
    for (int i = 0; i < 18; i++) begin
      if (i < 17) sb.push_back(8'(i + 1));
      bus_if.uart_we = 1'b1;
      bus_if.data_in = (i == 17) ? 32'h0000_00EE : 32'(i + 1);
      @(negedge clk);
      exp_cnt = (i < 2) ? 1 : ((i < 16) ? i : 16);
      check("ovf_count",   bus_if.fifo_count, exp_cnt);
      check("ovf_wr_drop", bus_if.wr_drop, (i == 17) ? 1 : 0);
      if (i == 16) check("ovf_full", bus_if.fifo_full, 1);
    end
    bus_if.uart_we = 1'b0;
    @(negedge clk);
    check("ovf_drop_pulse_end", bus_if.wr_drop, 0);
    check("ovf_count_hold",     bus_if.fifo_count, 16);
    check("ovf_full_hold",      bus_if.fifo_full, 1);
    guard = 0;
    while (bus_if.tx_busy && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("ovf_drained", bus_if.tx_busy, 0);
    repeat (3) @(negedge clk);
    check("ovf_sb_empty", sb.size(), 0);
    check("ovf_count_end", bus_if.fifo_count, 0);

    // Asynchronous reset during DATA bit 4 of an all-zero frame
    for (int i = 0; i < 3; i++) begin
      sb.push_back(8'h00);
      bus_if.uart_we = 1'b1;
      bus_if.data_in = '0;
      @(negedge clk);
    end
    bus_if.uart_we = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_rst_tx",   tx, 0);
    check("pre_rst_busy", bus_if.tx_busy, 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_tx",    tx, 1);
    check("async_rst_busy",  bus_if.tx_busy, 0);
    check("async_rst_count", bus_if.fifo_count, 0);
    sb.delete();
    repeat (5) @(negedge clk);
    rst = 1'b0;
    ok = 1'b1;
    repeat (80) begin
      @(negedge clk);
      if (tx !== 1'b1 || bus_if.tx_busy !== 1'b0 || bus_if.fifo_count !== '0) ok = 1'b0;
    end
    check("post_rst_quiet", ok, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
